// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised serial line to parallel byte, LSB first, sampled mid-bit.
// Latency ~2 + (CLOCKS_PER_BIT-1)/2 + 9*CLOCKS_PER_BIT + 1 cycles from start edge; no backpressure, valid/err are single-cycle pulses.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 1302
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_bit,
    output logic       o_rx_data_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_active,
    output logic       o_rx_frame_err
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MID = CW'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] CNT_END = CW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          data_vld_nxt, frame_err_nxt;
    logic          rx_meta, rx_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_bit;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift_reg;
        data_vld_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch
                if (clk_cnt == CNT_MID) begin
                    state_nxt   = rx_s ? IDLE : DATA;
                    bit_idx_nxt = 3'd0;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_END) begin
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (clk_cnt == CNT_END) begin
                    data_vld_nxt  = rx_s;
                    frame_err_nxt = !rx_s;
                    state_nxt     = CLEANUP;
                end
            end
            CLEANUP: begin
                // Holding here until the line is high keeps a break from re-triggering START
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state || clk_cnt == CNT_END || state == IDLE || state == CLEANUP)
            clk_cnt_nxt = '0;
        else
            clk_cnt_nxt = clk_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            clk_cnt         <= '0;
            bit_idx         <= 3'd0;
            shift_reg       <= 8'h00;
            o_rx_data       <= 8'h00;
            o_rx_data_valid <= 1'b0;
            o_rx_frame_err  <= 1'b0;
        end else begin
            state           <= state_nxt;
            clk_cnt         <= clk_cnt_nxt;
            bit_idx         <= bit_idx_nxt;
            shift_reg       <= shift_nxt;
            o_rx_data_valid <= data_vld_nxt;
            o_rx_frame_err  <= frame_err_nxt;
            if (data_vld_nxt) o_rx_data <= shift_reg;
        end
    end

    assign o_rx_active = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: fast instance (16 clocks/bit) plus a 1302 clocks/bit instance for the loopback case.
module tb_uart_rx;

    localparam int CPB      = 16;
    localparam int CPB_SLOW = 1302;

    logic       clk;
    logic       rst_n;
    logic       rx_line;
    logic       rx_line_slow;
    logic       vld, err, act;
    logic [7:0] dat;
    logic       vld_s, err_s, act_s;
    logic [7:0] dat_s;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] rx_q[$];
    int         err_cnt = 0;
    int         both_seen = 0;
    logic [7:0] slow_q[$];
    int         slow_err_cnt = 0;

    uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_bit(rx_line),
        .o_rx_data_valid(vld), .o_rx_data(dat), .o_rx_active(act), .o_rx_frame_err(err)
    );

    uart_rx #(.CLOCKS_PER_BIT(CPB_SLOW)) dut_slow (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_bit(rx_line_slow),
        .o_rx_data_valid(vld_s), .o_rx_data(dat_s), .o_rx_active(act_s), .o_rx_frame_err(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vld) rx_q.push_back(dat);
        if (err) err_cnt++;
        if (vld && err) both_seen++;
        if (vld_s) slow_q.push_back(dat_s);
        if (err_s) slow_err_cnt++;
        if (vld_s && err_s) both_seen++;
    end

    task automatic drive_bit(input logic b);
        rx_line = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx_line = 1'b1;
        rx_line_slow = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({vld, dat, act, err} !== 11'h000) begin
            n_mis++;
            $display("FAIL reset_fast: got vld=%b dat=%h act=%b err=%b, want all 0", vld, dat, act, err);
        end
        n_cmp++;
        if ({vld_s, dat_s, act_s, err_s} !== 11'h000) begin
            n_mis++;
            $display("FAIL reset_slow: got vld=%b dat=%h act=%b err=%b, want all 0", vld_s, dat_s, act_s, err_s);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_loopback_slow;
        slow_q.delete();
        rx_line_slow = 1'b0;
        repeat (CPB_SLOW) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line_slow = 8'h3F >> i;
            repeat (CPB_SLOW) @(negedge clk);
        end
        rx_line_slow = 1'b1;
        repeat (CPB_SLOW + 20) @(negedge clk);
        n_cmp++;
        if (slow_q.size() != 1) begin
            n_mis++;
            $display("FAIL slow_count: got %0d valid pulses, want 1", slow_q.size());
        end else begin
            n_cmp++;
            if (slow_q[0] !== 8'h3F) begin
                n_mis++;
                $display("FAIL slow_data: got %h, want 3f", slow_q[0]);
            end
        end
        n_cmp++;
        if (slow_err_cnt != 0) begin
            n_mis++;
            $display("FAIL slow_err: got %0d error pulses, want 0", slow_err_cnt);
        end
    endtask

    task automatic test_loopback_fast;
        rx_q.delete();
        send_frame(8'h3F, 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != 1 || dat !== 8'h3F) begin
            n_mis++;
            $display("FAIL fast_3f: got %0d pulses data=%h, want 1 pulse data=3f", rx_q.size(), dat);
        end
        n_cmp++;
        if (err_cnt != 0) begin
            n_mis++;
            $display("FAIL fast_err: got %0d error pulses, want 0", err_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp[4];
        exp = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
        rx_q.delete();
        for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != 4) begin
            n_mis++;
            $display("FAIL b2b_count: got %0d pulses, want 4", rx_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rx_q[i] !== exp[i]) begin
                    n_mis++;
                    $display("FAIL b2b_byte%0d: got %h, want %h", i, rx_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_glitch;
        int act_cycles;
        int err_before;
        act_cycles = 0;
        err_before = err_cnt;
        rx_q.delete();
        rx_line = 1'b0;
        repeat (5) @(negedge clk);
        rx_line = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (act) act_cycles++;
            @(negedge clk);
        end
        n_cmp++;
        if (act_cycles == 0 || act_cycles >= 10) begin
            n_mis++;
            $display("FAIL glitch_active: got %0d active cycles, want 1..9", act_cycles);
        end
        n_cmp++;
        if (rx_q.size() != 0 || err_cnt != err_before || act !== 1'b0) begin
            n_mis++;
            $display("FAIL glitch_quiet: got %0d valid, %0d err, act=%b, want 0, 0, 0",
                     rx_q.size(), err_cnt - err_before, act);
        end
    endtask

    task automatic test_frame_err;
        int err_before;
        err_before = err_cnt;
        rx_q.delete();
        send_frame(8'hC3, 1'b0);
        rx_line = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        n_cmp++;
        if (err_cnt - err_before != 1) begin
            n_mis++;
            $display("FAIL ferr_pulse: got %0d error pulses, want 1", err_cnt - err_before);
        end
        n_cmp++;
        if (rx_q.size() != 0 || dat !== 8'h5A) begin
            n_mis++;
            $display("FAIL ferr_data: got %0d valid data=%h, want 0 valid data=5a", rx_q.size(), dat);
        end
        n_cmp++;
        if (act !== 1'b1) begin
            n_mis++;
            $display("FAIL ferr_stuck_active: got act=%b, want 1", act);
        end
        rx_line = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (act !== 1'b0) begin
            n_mis++;
            $display("FAIL ferr_release: got act=%b, want 0", act);
        end
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != 1 || dat !== 8'h81) begin
            n_mis++;
            $display("FAIL ferr_next: got %0d pulses data=%h, want 1 pulse data=81", rx_q.size(), dat);
        end
    endtask

    task automatic test_reset_midframe;
        rx_q.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(8'h96 >> i);
        rx_line = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({vld, dat, act, err} !== 11'h000) begin
            n_mis++;
            $display("FAIL midrst_outputs: got vld=%b dat=%h act=%b err=%b, want all 0", vld, dat, act, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != 0) begin
            n_mis++;
            $display("FAIL midrst_novalid: got %0d valid pulses, want 0", rx_q.size());
        end
        send_frame(8'h69, 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != 1 || dat !== 8'h69) begin
            n_mis++;
            $display("FAIL midrst_next: got %0d pulses data=%h, want 1 pulse data=69", rx_q.size(), dat);
        end
    endtask

    task automatic test_timing;
        int cyc;
        logic width_ok;
        cyc = 0;
        width_ok = 1'b1;
        rx_q.delete();
        fork
            send_frame(8'h3C, 1'b1);
            begin
                while (cyc < 400 && vld !== 1'b1) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                @(posedge clk);
                #1;
                width_ok = (vld === 1'b0);
            end
        join
        @(negedge clk);
        n_cmp++;
        if (cyc < 153 || cyc > 155) begin
            n_mis++;
            $display("FAIL timing_latency: got %0d cycles, want 154 +/-1", cyc);
        end
        n_cmp++;
        if (!width_ok) begin
            n_mis++;
            $display("FAIL timing_width: got pulse wider than 1 cycle, want exactly 1");
        end
        n_cmp++;
        if (dat !== 8'h3C) begin
            n_mis++;
            $display("FAIL timing_data: got %h, want 3c", dat);
        end
    endtask

    initial begin
        test_reset;
        test_loopback_slow;
        test_loopback_fast;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_midframe;
        test_timing;
        n_cmp++;
        if (both_seen != 0) begin
            n_mis++;
            $display("FAIL vld_err_overlap: got %0d cycles with both high, want 0", both_seen);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
